// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter
//
// Packet-level round-robin arbiter that shares the single MAC ff_tx FIFO port
// between two packet sources in the sys_clk domain:
//   source 0 - ADC/scan data stream
//   source 1 - command/status responder
// A granted packet is forwarded whole (sop..eop) and packets never interleave.
// The data path is a purely combinational mux, so it adds no register stages.
//
// Parameters
//   DATA_W  data bus width on both sources and on the MAC side
//   CNT_W   per-source packet counter width (only with TX_ARB_STATS_EN)
//
// Ports
//   clk                 system clock, same as MAC ff_tx_clk
//   reset               synchronous, active-high reset
//   i_sN_data/vld/sop/eop, o_sN_rdy   source N (N = 0, 1) streaming interface
//   o_tx_data/vld/sop/eop             to MAC ff_tx_data/wren/sop/eop
//   i_tx_rdy                          from MAC ff_tx_rdy
//   o_grant             one-hot current grant, 2'b00 while idle
//   o_sop_err           1-cycle pulse when an orphan beat (vld without sop)
//                       is discarded while idle
//   o_pkt_cnt0/1        wrapping count of eop beats transferred per source
//                       (only with TX_ARB_STATS_EN)
//
// Configuration macro
//   TX_ARB_STATS_EN     adds the per-source packet counters and their ports

`timescale 1ns / 1ps

module mac_tx_arbiter #(
    parameter int unsigned DATA_W = 32
`ifdef TX_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [DATA_W-1:0] i_s0_data,
    input  logic              i_s0_vld,
    input  logic              i_s0_sop,
    input  logic              i_s0_eop,
    output logic              o_s0_rdy,

    input  logic [DATA_W-1:0] i_s1_data,
    input  logic              i_s1_vld,
    input  logic              i_s1_sop,
    input  logic              i_s1_eop,
    output logic              o_s1_rdy,

    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_vld,
    output logic              o_tx_sop,
    output logic              o_tx_eop,
    input  logic              i_tx_rdy,

    output logic [1:0]        o_grant,
    output logic              o_sop_err
`ifdef TX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  o_pkt_cnt0,
    output logic [CNT_W-1:0]  o_pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } state_e;

    state_e state_q, state_d;

    // 1 = source 1 held the most recent grant. Resetting to 1 lets source 0
    // win the first tie.
    logic last_q, last_d;

    logic req0, req1;
    logic orphan0, orphan1;
    logic eop_xfer0, eop_xfer1;

    // A request is a valid start-of-packet beat; a valid beat without sop in
    // idle cannot belong to any granted packet and is dropped.
    assign req0    = i_s0_vld & i_s0_sop;
    assign req1    = i_s1_vld & i_s1_sop;
    assign orphan0 = i_s0_vld & ~i_s0_sop;
    assign orphan1 = i_s1_vld & ~i_s1_sop;

    // Final beat of the granted packet accepted by the MAC.
    assign eop_xfer0 = (state_q == StGnt0) & i_s0_vld & i_tx_rdy & i_s0_eop;
    assign eop_xfer1 = (state_q == StGnt1) & i_s1_vld & i_tx_rdy & i_s1_eop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        o_tx_data = '0;
        o_tx_vld  = 1'b0;
        o_tx_sop  = 1'b0;
        o_tx_eop  = 1'b0;
        o_s0_rdy  = 1'b0;
        o_s1_rdy  = 1'b0;
        o_grant   = 2'b00;
        o_sop_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Orphan beats are accepted and thrown away so the source
                // can make progress towards its next sop.
                o_s0_rdy  = orphan0;
                o_s1_rdy  = orphan1;
                o_sop_err = orphan0 | orphan1;

                if (req0 && req1) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (req0) begin
                    state_d = StGnt0;
                end else if (req1) begin
                    state_d = StGnt1;
                end
            end

            StGnt0: begin
                o_tx_vld  = i_s0_vld;
                o_tx_data = i_s0_vld ? i_s0_data : '0;
                o_tx_sop  = i_s0_sop;
                o_tx_eop  = i_s0_eop;
                o_s0_rdy  = i_tx_rdy;
                o_grant   = 2'b01;
                if (eop_xfer0) begin
                    state_d = StIdle;
                    last_d  = 1'b0;
                end
            end

            StGnt1: begin
                o_tx_vld  = i_s1_vld;
                o_tx_data = i_s1_vld ? i_s1_data : '0;
                o_tx_sop  = i_s1_sop;
                o_tx_eop  = i_s1_eop;
                o_s1_rdy  = i_tx_rdy;
                o_grant   = 2'b10;
                if (eop_xfer1) begin
                    state_d = StIdle;
                    last_d  = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef TX_ARB_STATS_EN
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt1_q;

    // Counters wrap naturally at all-ones; orphan beats never reach a grant
    // state, so they are never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            if (eop_xfer0) begin
                pkt_cnt0_q <= pkt_cnt0_q + CNT_W'(1);
            end
            if (eop_xfer1) begin
                pkt_cnt1_q <= pkt_cnt1_q + CNT_W'(1);
            end
        end
    end

    assign o_pkt_cnt0 = pkt_cnt0_q;
    assign o_pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule
